// File: rtl/button_pkg.sv
// Shared defaults and arbiter state encoding for the push-button front end.
package button_pkg;

  localparam int unsigned N_BTN_DEFAULT           = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/button_debouncer.sv
// One button bit: 2-flop synchroniser, stable-run debounce counter, debounced
// level and a registered one-cycle press pulse on each accepted 0->1 change.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // Any agreeing cycle restarts the run; the final differing cycle flips the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces N buttons, latches presses as pending requests and offers them
// round-robin on a valid/ready event stream with one idle bubble per event.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int unsigned N_BTN           = N_BTN_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  localparam int unsigned ID_W           = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_dropped
);

  logic [N_BTN-1:0] level_w, press_w;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (btn_raw[g]),
      .level_o(level_w[g]),
      .press_o(press_w[g])
    );
  end

  arb_state_t       state_q, state_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic             evt_valid_q, evt_valid_d;
  logic             dropped_q, dropped_d;
  logic [N_BTN-1:0] clr_c;
  logic [ID_W-1:0]  pick_c;
  logic             pick_found_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      pending_q   <= '0;
      evt_id_q    <= '0;
      last_q      <= ID_W'(N_BTN - 1);
      evt_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      evt_id_q    <= evt_id_d;
      last_q      <= last_d;
      evt_valid_q <= evt_valid_d;
      dropped_q   <= dropped_d;
    end
  end

  // First pending request strictly after the last grant, wrapping modulo N_BTN.
  always_comb begin
    int unsigned idx;
    idx          = 0;
    pick_c       = '0;
    pick_found_c = 1'b0;
    for (int unsigned k = 1; k <= N_BTN; k++) begin
      idx = (int'(last_q) + k) % N_BTN;
      if (!pick_found_c && pending_q[ID_W'(idx)]) begin
        pick_found_c = 1'b1;
        pick_c       = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    evt_id_d    = evt_id_q;
    last_d      = last_q;
    evt_valid_d = evt_valid_q;
    clr_c       = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found_c) begin
          evt_id_d    = pick_c;
          evt_valid_d = 1'b1;
          state_d     = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        if (evt_ready) begin
          clr_c[evt_id_q] = 1'b1;
          last_d          = evt_id_q;
          evt_valid_d     = 1'b0;
          state_d         = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // A press landing on the slot being cleared survives as a fresh request.
    pending_d = (pending_q & ~clr_c) | press_w;
    dropped_d = |(press_w & pending_q & ~clr_c);
  end

  assign evt_valid   = evt_valid_q;
  assign evt_id      = evt_id_q;
  assign btn_level   = level_w;
  assign evt_dropped = dropped_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed scenarios plus random traffic, compared every cycle against a
// behavioural model of the button front end (N_BTN=4, DEBOUNCE_CYCLES=4).
module tb_button_event_arbiter;

  localparam int N   = 4;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [3:0] btn_level;
  logic       evt_dropped;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [3:0] rawq[$];
  bit         m_lvl[N];
  int         m_run[N];
  bit         m_rose[N];
  bit         m_pend[N];
  bit         m_off;
  int         m_oid;
  int         m_last;
  bit         m_drop;
  int         hs_q[$];
  int         exp_q[$];
  int         drop_cnt;
  int         coincide_cnt;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_id     (evt_id),
    .btn_level  (btn_level),
    .evt_dropped(evt_dropped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_lvl[i] = 0; m_run[i] = 0; m_rose[i] = 0; m_pend[i] = 0;
    end
    m_off  = 0;
    m_oid  = 0;
    m_last = N - 1;
    m_drop = 0;
    rawq   = {4'h0, 4'h0};
  endtask

  // One clock edge of the model, using the inputs currently applied.
  task automatic model_edge();
    logic [3:0] s;
    bit press[N];
    bit clr[N];
    bit hs, any_pend, drop, found;
    int idx;
    if (reset) begin
      model_reset();
      return;
    end
    s = rawq.pop_front();
    rawq.push_back(btn_raw);
    hs = m_off && evt_ready;
    any_pend = 0;
    drop = 0;
    for (int i = 0; i < N; i++) begin
      press[i] = m_rose[i];
      clr[i]   = hs && (m_oid == i);
      if (m_pend[i]) any_pend = 1;
      if (press[i] && m_pend[i] && !clr[i]) drop = 1;
      if (press[i] && clr[i]) coincide_cnt++;
    end
    if (hs) begin
      hs_q.push_back(m_oid);
      m_last = m_oid;
      m_off  = 0;
    end else if (!m_off && any_pend) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && m_pend[idx]) begin
          found = 1;
          m_oid = idx;
        end
      end
      m_off = 1;
    end
    for (int i = 0; i < N; i++) m_pend[i] = (m_pend[i] && !clr[i]) || press[i];
    m_drop = drop;
    if (drop) drop_cnt++;
    // A level is accepted after DEB consecutive differing synchronised samples.
    for (int i = 0; i < N; i++) begin
      m_rose[i] = 0;
      if (s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i]  = !m_lvl[i];
          m_run[i]  = 0;
          m_rose[i] = m_lvl[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic cyc();
    logic [3:0] lv;
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) lv[i] = m_lvl[i];
    chk("evt_valid", 32'(evt_valid), 32'(m_off));
    chk("evt_id", 32'(evt_id), 32'(m_oid));
    chk("btn_level", 32'(btn_level), 32'(lv));
    chk("evt_dropped", 32'(evt_dropped), 32'(m_drop));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_count"}, 32'(hs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
      chk({tag, "_id"}, 32'(hs_q[i]), 32'(exp_q[i]));
    hs_q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    btn_raw   = 4'hF;
    evt_ready = 1'b1;
    drop_cnt  = 0;
    coincide_cnt = 0;
    model_reset();
    @(negedge clk);

    // Reset with all buttons held, then all four are served in index order
    run(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    reset = 1'b0;
    run(5);
    chk("early_level", 32'(btn_level), 32'h0);
    run(30);
    chk("late_level", 32'(btn_level), 32'hF);
    exp_q = {0, 1, 2, 3};
    chk_seq("reset_order");
    btn_raw = 4'h0;
    run(15);

    // Bounce on button 1 never reaches the debounce threshold
    for (int k = 0; k < 10; k++) begin
      btn_raw[1] = ~btn_raw[1];
      run(2);
      chk("bounce_level", 32'(btn_level), 32'h0);
    end
    btn_raw[1] = 1'b1;
    run(20);
    exp_q = {1};
    chk_seq("bounce");
    btn_raw = 4'h0;
    run(15);

    // Round-robin: after a grant to 2, simultaneous 0 and 3 go 3 then 0
    btn_raw = 4'b0100;
    run(15);
    btn_raw = 4'b0000;
    run(10);
    btn_raw = 4'b1001;
    run(20);
    exp_q = {2, 3, 0};
    chk_seq("round_robin");
    btn_raw = 4'h0;
    run(15);

    // Backpressure holds id 1 while button 2 is pressed behind it
    evt_ready = 1'b0;
    btn_raw = 4'b0010;
    run(12);
    btn_raw = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      run(1);
      chk("bp_id", 32'(evt_id), 32'd1);
      chk("bp_valid", 32'(evt_valid), 32'd1);
    end
    evt_ready = 1'b1;
    run(1);
    chk("bp_bubble", 32'(evt_valid), 32'd0);
    run(1);
    chk("bp_next_valid", 32'(evt_valid), 32'd1);
    chk("bp_next_id", 32'(evt_id), 32'd2);
    run(10);
    exp_q = {1, 2};
    chk_seq("backpressure");
    btn_raw = 4'h0;
    run(15);

    // Second press on a still-pending button is dropped with one pulse
    drop_cnt = 0;
    evt_ready = 1'b0;
    btn_raw = 4'b0001;
    run(12);
    btn_raw = 4'b0000;
    run(12);
    btn_raw = 4'b0001;
    run(12);
    evt_ready = 1'b1;
    run(12);
    chk("drop_pulses", 32'(drop_cnt), 32'd1);
    exp_q = {0};
    chk_seq("drop");
    btn_raw = 4'h0;
    run(15);

    // Re-press of 3 lands on the handshake cycle of the first id 3 event
    drop_cnt = 0;
    coincide_cnt = 0;
    evt_ready = 1'b0;
    btn_raw = 4'b1000;
    run(12);
    btn_raw = 4'b0000;
    run(12);
    btn_raw = 4'b1000;
    run(6);
    evt_ready = 1'b1;
    run(12);
    chk("same_cycle_hit", 32'(coincide_cnt), 32'd1);
    chk("same_cycle_drop", 32'(drop_cnt), 32'd0);
    exp_q = {3, 3};
    chk_seq("same_cycle");
    btn_raw = 4'h0;
    run(15);

    // Random buttons, ready and occasional reset against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) btn_raw[$urandom_range(0, 3)] ^= 1'b1;
      evt_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
